redirect_controller: RTL and testbench

Sequences front-end recovery after a control-flow redirect in the dual-issue pipeline. It accepts redirect requests from the execute-stage recovery logic and from decode-stage early-jump logic, and arbitrates between them by program order (EX is older, so EX wins). It drives a valid/ready redirect handshake to the PC control unit and squashes fetch/decode for a programmable drain window. It also keeps saturating redirect and misprediction counters.

---
 rtl/redirect_controller.sv | 147 ++++++++++++++
 tb/tb_redirect_controller.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/redirect_controller.sv
// Front-end redirect sequencer for the dual-issue pipeline.
// Arbitrates EX-stage recovery against decode-stage early jumps (EX is older
// and always wins), presents the winner to PC control over a valid/ready
// handshake, then holds the front end squashed for DRAIN_CYCLES cycles.
// Keeps saturating counters of completed redirects and EX mispredictions.
module redirect_controller #(
   parameter int DRAIN_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_recover_en,
   input  logic [31:0]       ex_recover_pc,
   input  logic              ex_flush1,
   input  logic              ex_flush2,
   input  logic              ex_miss,
   input  logic              id_redirect_en,
   input  logic [31:0]       id_redirect_pc,
   output logic              pc_redirect_valid,
   output logic [31:0]       pc_redirect_pc,
   input  logic              pc_redirect_ready,
   output logic              kill_if,
   output logic              kill_id,
   output logic              kill_ex_slot2,
   output logic              stall_issue,
   output logic [CNT_W-1:0]  redirect_count,
   output logic [CNT_W-1:0]  miss_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

   state_t            state_reg;
   logic [31:0]       tgt_pc_reg;
   logic              src_ex_reg;      // 1: current redirect came from EX, 0: from ID
   logic [3:0]        drain_cnt_reg;
   logic [CNT_W-1:0]  redirect_count_reg;
   logic [CNT_W-1:0]  miss_count_reg;
   logic              valid_reg;
   logic              busy_reg;

   logic              idle;
   logic              accept_ex;
   logic              accept_id;
   logic              accept_any;
   logic              handshake;

   // ex_flush2 only matters when ex_flush1 is clear, and then slot 2 retires
   // normally, so it never changes the squash decision.
   logic              unused_flush2;
   assign unused_flush2 = ex_flush2;

   assign idle = (state_reg == IDLE);

   // EX is accepted when idle, or when it preempts an in-flight ID redirect.
   // A busy EX redirect means any new request comes from a squashed younger op.
   assign accept_ex  = !rst && ex_recover_en && (idle || !src_ex_reg);
   assign accept_id  = !rst && id_redirect_en && !ex_recover_en && idle;
   assign accept_any = accept_ex || accept_id;
   assign handshake  = (state_reg == REQ) && pc_redirect_ready;

   // Accept-cycle kills are combinational so the stages are squashed at once.
   always_comb begin
      kill_if       = accept_any || busy_reg;
      kill_id       = accept_ex  || busy_reg;
      kill_ex_slot2 = accept_ex  && ex_flush1;
   end

   assign pc_redirect_valid = valid_reg;
   assign pc_redirect_pc    = tgt_pc_reg;
   assign stall_issue       = busy_reg;
   assign redirect_count    = redirect_count_reg;
   assign miss_count        = miss_count_reg;

   // Redirect FSM, target/source capture, drain timer and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         tgt_pc_reg    <= 32'd0;
         src_ex_reg    <= 1'b1;
         drain_cnt_reg <= 4'd0;
         valid_reg     <= 1'b0;
         busy_reg      <= 1'b0;
      end else if (accept_ex) begin
         // Fresh EX request; also replaces an ID redirect in REQ or DRAIN.
         // A same-cycle ID handshake still completes and is counted below.
         tgt_pc_reg <= ex_recover_pc;
         src_ex_reg <= 1'b1;
         state_reg  <= REQ;
         valid_reg  <= 1'b1;
         busy_reg   <= 1'b1;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept_id) begin
                  tgt_pc_reg <= id_redirect_pc;
                  src_ex_reg <= 1'b0;
                  state_reg  <= REQ;
                  valid_reg  <= 1'b1;
                  busy_reg   <= 1'b1;
               end
            end
            REQ: begin
               if (pc_redirect_ready) begin
                  state_reg     <= DRAIN;
                  drain_cnt_reg <= DRAIN_INIT;
                  valid_reg     <= 1'b0;
               end
            end
            DRAIN: begin
               if (drain_cnt_reg == 4'd0) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end else begin
                  drain_cnt_reg <= drain_cnt_reg - 4'd1;
               end
            end
            default: begin
               state_reg <= IDLE;
               valid_reg <= 1'b0;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   // Saturating statistics counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         redirect_count_reg <= '0;
         miss_count_reg     <= '0;
      end else begin
         if (handshake && (redirect_count_reg != '1)) begin
            redirect_count_reg <= redirect_count_reg + CNT_W'(1);
         end
         if (accept_ex && ex_miss && (miss_count_reg != '1)) begin
            miss_count_reg <= miss_count_reg + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_redirect_controller.sv
// Directed bench for redirect_controller: a per-cycle vector table covering
// EX/ID redirects, backpressure, priority, preemption and ignored younger
// requests, followed by hand sequences for reset mid-REQ and saturation.
module tb_redirect_controller;

   logic        clk;
   logic        rst;
   logic        ex_recover_en;
   logic [31:0] ex_recover_pc;
   logic        ex_flush1;
   logic        ex_flush2;
   logic        ex_miss;
   logic        id_redirect_en;
   logic [31:0] id_redirect_pc;
   logic        pc_redirect_valid;
   logic [31:0] pc_redirect_pc;
   logic        pc_redirect_ready;
   logic        kill_if;
   logic        kill_id;
   logic        kill_ex_slot2;
   logic        stall_issue;
   logic [15:0] redirect_count;
   logic [15:0] miss_count;

   // Small-counter instance for saturation checks.
   logic        s_ex_en;
   logic        s_miss;
   logic        s_ready;
   logic        s_valid;
   logic [31:0] s_pc;
   logic        s_kill_if;
   logic        s_kill_id;
   logic        s_kill_ex2;
   logic        s_stall;
   logic [2:0]  s_redirect_count;
   logic [2:0]  s_miss_count;

   int tests_run;
   int tests_failed;

   redirect_controller #(.DRAIN_CYCLES(2), .CNT_W(16)) dut (
      .clk               (clk),
      .rst               (rst),
      .ex_recover_en     (ex_recover_en),
      .ex_recover_pc     (ex_recover_pc),
      .ex_flush1         (ex_flush1),
      .ex_flush2         (ex_flush2),
      .ex_miss           (ex_miss),
      .id_redirect_en    (id_redirect_en),
      .id_redirect_pc    (id_redirect_pc),
      .pc_redirect_valid (pc_redirect_valid),
      .pc_redirect_pc    (pc_redirect_pc),
      .pc_redirect_ready (pc_redirect_ready),
      .kill_if           (kill_if),
      .kill_id           (kill_id),
      .kill_ex_slot2     (kill_ex_slot2),
      .stall_issue       (stall_issue),
      .redirect_count    (redirect_count),
      .miss_count        (miss_count)
   );

   redirect_controller #(.DRAIN_CYCLES(2), .CNT_W(3)) dut_sat (
      .clk               (clk),
      .rst               (rst),
      .ex_recover_en     (s_ex_en),
      .ex_recover_pc     (32'h0000_0C00),
      .ex_flush1         (1'b0),
      .ex_flush2         (1'b0),
      .ex_miss           (s_miss),
      .id_redirect_en    (1'b0),
      .id_redirect_pc    (32'h0),
      .pc_redirect_valid (s_valid),
      .pc_redirect_pc    (s_pc),
      .pc_redirect_ready (s_ready),
      .kill_if           (s_kill_if),
      .kill_id           (s_kill_id),
      .kill_ex_slot2     (s_kill_ex2),
      .stall_issue       (s_stall),
      .redirect_count    (s_redirect_count),
      .miss_count        (s_miss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        ex_en;
      logic [31:0] ex_pc;
      logic        f1;
      logic        f2;
      logic        miss;
      logic        id_en;
      logic [31:0] id_pc;
      logic        rdy;
      logic        valid;
      logic [31:0] pc;
      logic        kif;
      logic        kid;
      logic        kx2;
      logic        stall;
      logic [15:0] rc;
      logic [15:0] mc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic rst_i, input logic ex_en, input logic [31:0] ex_pc,
      input logic f1, input logic f2, input logic miss,
      input logic id_en, input logic [31:0] id_pc, input logic rdy,
      input logic valid, input logic [31:0] pc, input logic kif,
      input logic kid, input logic kx2, input logic stall,
      input logic [15:0] rc, input logic [15:0] mc);
      vec_t v;
      v.rst = rst_i; v.ex_en = ex_en; v.ex_pc = ex_pc; v.f1 = f1; v.f2 = f2;
      v.miss = miss; v.id_en = id_en; v.id_pc = id_pc; v.rdy = rdy;
      v.valid = valid; v.pc = pc; v.kif = kif; v.kid = kid; v.kx2 = kx2;
      v.stall = stall; v.rc = rc; v.mc = mc;
      return v;
   endfunction

   task automatic chk(input string name, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s (vec %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic drive_idle();
      rst = 1'b0; ex_recover_en = 1'b0; ex_recover_pc = 32'h0;
      ex_flush1 = 1'b0; ex_flush2 = 1'b0; ex_miss = 1'b0;
      id_redirect_en = 1'b0; id_redirect_pc = 32'h0; pc_redirect_ready = 1'b0;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      drive_idle();
      rst     = 1'b1;
      s_ex_en = 1'b0;
      s_miss  = 1'b0;
      s_ready = 1'b1;
      repeat (2) @(posedge clk);

      // rst ex_en ex_pc f1 f2 miss id_en id_pc rdy | valid pc kif kid kx2 stall rc mc
      vecs.push_back(mk(1,0,32'h0,0,0,0,0,32'h0,0, 0,32'h0,0,0,0,0,0,0));       // reset
      // Basic EX redirect, ready tied high
      vecs.push_back(mk(0,1,32'h1000,1,1,1,0,32'h0,1, 0,32'h0,1,1,1,0,0,0));
      vecs.push_back(mk(0,0,32'h0,0,0,0,0,32'h0,1, 1,32'h1000,1,1,0,1,0,1));
      vecs.push_back(mk(0,0,32'h0,0,0,0,0,32'h0,1, 0,32'h1000,1,1,0,1,1,1));
      vecs.push_back(mk(0,0,32'h0,0,0,0,0,32'h0,1, 0,32'h1000,1,1,0,1,1,1));
      vecs.push_back(mk(0,0,32'h0,0,0,0,0,32'h0,1, 0,32'h1000,0,0,0,0,1,1));
      // Backpressure on an ID redirect
      vecs.push_back(mk(0,0,32'h0,0,0,0,1,32'h200,0, 0,32'h1000,1,0,0,0,1,1));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(0,0,32'h0,0,0,0,0,32'h0,0, 1,32'h200,1,1,0,1,1,1));
      vecs.push_back(mk(0,0,32'h0,0,0,0,0,32'h0,1, 1,32'h200,1,1,0,1,1,1));
      vecs.push_back(mk(0,0,32'h0,0,0,0,0,32'h0,0, 0,32'h200,1,1,0,1,2,1));
      vecs.push_back(mk(0,0,32'h0,0,0,0,0,32'h0,0, 0,32'h200,1,1,0,1,2,1));
      vecs.push_back(mk(0,0,32'h0,0,0,0,0,32'h0,0, 0,32'h200,0,0,0,0,2,1));
      // Priority: EX and ID together; flush2 alone does not kill slot 2
      vecs.push_back(mk(0,1,32'h300,0,1,0,1,32'h400,0, 0,32'h200,1,1,0,0,2,1));
      vecs.push_back(mk(0,0,32'h0,0,0,0,1,32'h400,1, 1,32'h300,1,1,0,1,2,1));
      vecs.push_back(mk(0,0,32'h0,0,0,0,0,32'h0,0, 0,32'h300,1,1,0,1,3,1));
      vecs.push_back(mk(0,0,32'h0,0,0,0,0,32'h0,0, 0,32'h300,1,1,0,1,3,1));
      vecs.push_back(mk(0,0,32'h0,0,0,0,0,32'h0,0, 0,32'h300,0,0,0,0,3,1));
      // Preemption of ID in REQ with same-cycle ready
      vecs.push_back(mk(0,0,32'h0,0,0,0,1,32'h400,0, 0,32'h300,1,0,0,0,3,1));
      vecs.push_back(mk(0,0,32'h0,0,0,0,0,32'h0,0, 1,32'h400,1,1,0,1,3,1));
      vecs.push_back(mk(0,1,32'h500,0,0,1,0,32'h0,1, 1,32'h400,1,1,0,1,3,1));
      vecs.push_back(mk(0,0,32'h0,0,0,0,0,32'h0,1, 1,32'h500,1,1,0,1,4,2));
      vecs.push_back(mk(0,0,32'h0,0,0,0,0,32'h0,0, 0,32'h500,1,1,0,1,5,2));
      vecs.push_back(mk(0,0,32'h0,0,0,0,0,32'h0,0, 0,32'h500,1,1,0,1,5,2));
      vecs.push_back(mk(0,0,32'h0,0,0,0,0,32'h0,0, 0,32'h500,0,0,0,0,5,2));
      // Preemption of ID in REQ without ready; younger requests then ignored
      vecs.push_back(mk(0,0,32'h0,0,0,0,1,32'h400,0, 0,32'h500,1,0,0,0,5,2));
      vecs.push_back(mk(0,1,32'h500,1,0,0,0,32'h0,0, 1,32'h400,1,1,1,1,5,2));
      vecs.push_back(mk(0,0,32'h0,0,0,0,1,32'h600,0, 1,32'h500,1,1,0,1,5,2));
      vecs.push_back(mk(0,0,32'h0,0,0,0,0,32'h0,1, 1,32'h500,1,1,0,1,5,2));
      vecs.push_back(mk(0,1,32'h700,1,0,1,0,32'h0,0, 0,32'h500,1,1,0,1,6,2));
      vecs.push_back(mk(0,1,32'h700,1,0,1,0,32'h0,0, 0,32'h500,1,1,0,1,6,2));
      vecs.push_back(mk(0,0,32'h0,0,0,0,0,32'h0,0, 0,32'h500,0,0,0,0,6,2));
      // Preemption of ID in DRAIN
      vecs.push_back(mk(0,0,32'h0,0,0,0,1,32'h800,1, 0,32'h500,1,0,0,0,6,2));
      vecs.push_back(mk(0,0,32'h0,0,0,0,0,32'h0,1, 1,32'h800,1,1,0,1,6,2));
      vecs.push_back(mk(0,1,32'h900,0,0,0,0,32'h0,0, 0,32'h800,1,1,0,1,7,2));
      vecs.push_back(mk(0,0,32'h0,0,0,0,0,32'h0,0, 1,32'h900,1,1,0,1,7,2));
      vecs.push_back(mk(0,0,32'h0,0,0,0,0,32'h0,1, 1,32'h900,1,1,0,1,7,2));
      vecs.push_back(mk(0,0,32'h0,0,0,0,0,32'h0,0, 0,32'h900,1,1,0,1,8,2));
      vecs.push_back(mk(0,0,32'h0,0,0,0,0,32'h0,0, 0,32'h900,1,1,0,1,8,2));
      vecs.push_back(mk(0,0,32'h0,0,0,0,0,32'h0,0, 0,32'h900,0,0,0,0,8,2));

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rst               = vecs[i].rst;
         ex_recover_en     = vecs[i].ex_en;
         ex_recover_pc     = vecs[i].ex_pc;
         ex_flush1         = vecs[i].f1;
         ex_flush2         = vecs[i].f2;
         ex_miss           = vecs[i].miss;
         id_redirect_en    = vecs[i].id_en;
         id_redirect_pc    = vecs[i].id_pc;
         pc_redirect_ready = vecs[i].rdy;
         #1;
         $display("[TB] vec %0d: valid=%0b pc=0x%0h kif=%0b kid=%0b kx2=%0b stall=%0b rc=%0d mc=%0d",
                  i, pc_redirect_valid, pc_redirect_pc, kill_if, kill_id,
                  kill_ex_slot2, stall_issue, redirect_count, miss_count);
         chk("valid", i, 32'(pc_redirect_valid), 32'(vecs[i].valid));
         chk("pc",    i, pc_redirect_pc,         vecs[i].pc);
         chk("kill_if", i, 32'(kill_if),         32'(vecs[i].kif));
         chk("kill_id", i, 32'(kill_id),         32'(vecs[i].kid));
         chk("kill_ex_slot2", i, 32'(kill_ex_slot2), 32'(vecs[i].kx2));
         chk("stall_issue", i, 32'(stall_issue), 32'(vecs[i].stall));
         chk("redirect_count", i, 32'(redirect_count), 32'(vecs[i].rc));
         chk("miss_count", i, 32'(miss_count),   32'(vecs[i].mc));
      end

      // Reset asserted while a request is pending
      @(negedge clk);
      drive_idle();
      id_redirect_en = 1'b1;
      id_redirect_pc = 32'h0000_0A00;
      @(negedge clk);
      drive_idle();
      #1;
      chk("rst_pre_valid", 100, 32'(pc_redirect_valid), 32'd1);
      chk("rst_pre_pc", 100, pc_redirect_pc, 32'h0000_0A00);
      rst = 1'b1;
      pc_redirect_ready = 1'b1;
      ex_recover_en = 1'b1;
      ex_recover_pc = 32'h0000_0B00;
      ex_miss = 1'b1;
      @(negedge clk);
      drive_idle();
      #1;
      $display("[TB] reset-mid-REQ: valid=%0b pc=0x%0h rc=%0d mc=%0d",
               pc_redirect_valid, pc_redirect_pc, redirect_count, miss_count);
      chk("rst_valid", 101, 32'(pc_redirect_valid), 32'd0);
      chk("rst_pc", 101, pc_redirect_pc, 32'd0);
      chk("rst_kill_if", 101, 32'(kill_if), 32'd0);
      chk("rst_kill_id", 101, 32'(kill_id), 32'd0);
      chk("rst_stall", 101, 32'(stall_issue), 32'd0);
      chk("rst_redirect_count", 101, 32'(redirect_count), 32'd0);
      chk("rst_miss_count", 101, 32'(miss_count), 32'd0);

      // Saturation on the 3-bit counter instance
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         s_ex_en = 1'b1;
         s_miss  = 1'b1;
         @(negedge clk);
         s_ex_en = 1'b0;
         s_miss  = 1'b0;
         repeat (4) @(negedge clk);
         #1;
         $display("[TB] sat %0d: rc=%0d mc=%0d", i, s_redirect_count, s_miss_count);
         chk("sat_miss_count", 200 + i, 32'(s_miss_count), (i + 1 > 7) ? 32'd7 : 32'(i + 1));
         chk("sat_redirect_count", 200 + i, 32'(s_redirect_count), (i + 1 > 7) ? 32'd7 : 32'(i + 1));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
